// File: rtl/timer_seq_pkg.sv
// Shared types and helpers for the timer phase sequencer.
// State encoding for the sequencer FSM and the phase-index width helper.
package timer_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Minimum width 1 so a single-value index still has a port bit.
    function automatic int unsigned CeilLog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v != 0; v = v >> 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_tick_counter.sv
// Modulo-len_q cycle counter; wrap flags the last cycle of a phase while enabled.
module phase_tick_counter
    import timer_seq_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [LEN_W-1:0] len_q,
    output logic [LEN_W-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == (len_q - LEN_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + LEN_W'(1);
        end
    end

endmodule

// File: rtl/timer_phase_sequencer.sv
// Runs PHASES phases of len_q cycles each, with boundary ticks and a done pulse.
// Optional pause input enabled by defining TIMER_SEQ_PAUSE_EN.
module timer_phase_sequencer
    import timer_seq_pkg::*;
#(
    parameter  int unsigned PHASES  = 4,
    parameter  int unsigned LEN_W   = 8,
    localparam int unsigned PHASE_W = CeilLog2(PHASES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               loop_mode,
    input  logic               abort,
`ifdef TIMER_SEQ_PAUSE_EN
    input  logic               hold,
`endif
    output logic               busy,
    output logic [PHASE_W-1:0] phase,
    output logic [LEN_W-1:0]   count,
    output logic               tick,
    output logic               done
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic             loop_q;
    logic             hold_eff;
    logic             cnt_clr;
    logic             cnt_en;
    logic             wrap;

`ifdef TIMER_SEQ_PAUSE_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    // Counter is held at zero outside RUN and on abort, so abort beats a wrap.
    assign cnt_clr = (state != ST_RUN) || abort;
    assign cnt_en  = (state == ST_RUN) && !abort && !hold_eff;

    phase_tick_counter #(
        .LEN_W(LEN_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .len_q (len_q),
        .count (count),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            phase  <= '0;
            tick   <= 1'b0;
            done   <= 1'b0;
            len_q  <= '0;
            loop_q <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            len_q  <= len;
                            loop_q <= loop_mode;
                            phase  <= '0;
                            state  <= ST_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        phase <= '0;
                    end else if (wrap) begin
                        tick <= 1'b1;
                        if (phase == LAST_PHASE) begin
                            phase <= '0;
                            if (!loop_q) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_phase_sequencer.sv
// Scoreboard bench for timer_phase_sequencer: elapsed-cycle reference model feeds a queue.
// Pause scenarios are included when TIMER_SEQ_PAUSE_EN is defined.
module tb_timer_phase_sequencer;

    localparam int unsigned PHASES  = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned PHASE_W = 2;
`ifdef TIMER_SEQ_PAUSE_EN
    localparam bit HAS_HOLD = 1'b1;
`else
    localparam bit HAS_HOLD = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               loop_mode = 1'b0;
    logic               abort = 1'b0;
    logic               hold = 1'b0;
    logic [LEN_W-1:0]   len = '0;
    logic               busy;
    logic               tick;
    logic               done;
    logic [PHASE_W-1:0] phase;
    logic [LEN_W-1:0]   count;

    always #5 clk = ~clk;

    timer_phase_sequencer #(
        .PHASES(PHASES),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .loop_mode(loop_mode),
        .abort    (abort),
`ifdef TIMER_SEQ_PAUSE_EN
        .hold     (hold),
`endif
        .busy     (busy),
        .phase    (phase),
        .count    (count),
        .tick     (tick),
        .done     (done)
    );

    typedef struct {
        int cyc;
        bit busy;
        int phase;
        int count;
        bit tick;
        bit done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_now = 0;

    // Reference model: mode 0 idle, 1 running, 2 done; m_e = run cycles elapsed.
    int m_mode = 0;
    int m_e    = 0;
    int m_L    = 0;
    bit m_lp   = 1'b0;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic chk(input string name, input int got, input int exp, input int cyc);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc == cyc_now) begin
                x = q.pop_front();
                chk("busy",  int'(busy),  int'(x.busy), x.cyc);
                chk("phase", int'(phase), x.phase,      x.cyc);
                chk("count", int'(count), x.count,      x.cyc);
                chk("tick",  int'(tick),  int'(x.tick), x.cyc);
                chk("done",  int'(done),  int'(x.done), x.cyc);
            end
        end
    end

    // Drive one cycle of inputs, advance the model across the coming edge, queue its view.
    task automatic step(input bit s, input int l, input bit lm, input bit ab, input bit hd);
        exp_t x;
        bit   t;
        bit   d;
        start     = s;
        len       = LEN_W'(l);
        loop_mode = lm;
        abort     = ab;
        hold      = hd;
        if (!HAS_HOLD) hd = 1'b0;
        t = 1'b0;
        d = 1'b0;
        case (m_mode)
            0: if (s) begin
                if (l != 0) begin
                    m_L = l; m_lp = lm; m_e = 0; m_mode = 1;
                end else begin
                    m_mode = 2; d = 1'b1;
                end
            end
            1: if (ab) begin
                m_mode = 0; m_e = 0;
            end else if (!hd) begin
                m_e++;
                if (m_e % m_L == 0) t = 1'b1;
                if (m_e == m_L * int'(PHASES)) begin
                    m_e = 0;
                    if (!m_lp) begin
                        m_mode = 2; d = 1'b1;
                    end
                end
            end
            default: m_mode = 0;
        endcase
        x.cyc   = cyc_now + 1;
        x.busy  = (m_mode != 0);
        x.count = (m_mode == 1) ? (m_e % m_L) : 0;
        x.phase = (m_mode == 1) ? ((m_e / m_L) % int'(PHASES)) : 0;
        x.tick  = t;
        x.done  = d;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  int'(busy),  0, cyc_now);
        chk({tag, "_phase"}, int'(phase), 0, cyc_now);
        chk({tag, "_count"}, int'(count), 0, cyc_now);
        chk({tag, "_tick"},  int'(tick),  0, cyc_now);
        chk({tag, "_done"},  int'(done),  0, cyc_now);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #1;
        start = 1'b0; abort = 1'b0; hold = 1'b0; len = '0; loop_mode = 1'b0;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        q.delete();
        m_mode = 0; m_e = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int l;
        bit lp;
        int lim;
        int c;
        #7;
        check_zero("reset");
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Single run, len 3: ticks every 3 cycles, done after 12.
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        idle(14);

        // len 1 in loop mode, then abort.
        step(1'b1, 1, 1'b1, 1'b0, 1'b0);
        idle(9);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Zero length goes straight to done; start while busy is ignored.
        step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle(16);

        // Abort on the wrap cycle.
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        idle(3);
        c = 0;
        while (m_mode == 1 && (m_e % m_L) != m_L - 1 && c < 10) begin
            idle(1);
            c++;
        end
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Async reset at phase 2, count 1, then a full run.
        step(1'b1, 2, 1'b0, 1'b0, 1'b0);
        idle(5);
        reset_mid();
        step(1'b1, 2, 1'b0, 1'b0, 1'b0);
        idle(10);

`ifdef TIMER_SEQ_PAUSE_EN
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        idle(1);
        repeat (4) step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(14);
`endif

        // Randomized runs with stray starts, aborts and holds.
        for (int r = 0; r < 30; r++) begin
            case ($urandom % 8)
                0:       l = 0;
                1:       l = 1;
                7:       l = (r % 10 == 7) ? 255 : int'($urandom_range(7, 20));
                default: l = int'($urandom_range(2, 6));
            endcase
            lp  = ($urandom % 4) == 0;
            lim = lp ? 40 : l * int'(PHASES) + 4;
            step(1'b1, l, lp, 1'b0, 1'b0);
            c = 0;
            while (m_mode != 0 && c < 1200) begin
                step(($urandom % 6) == 0, int'($urandom_range(0, 9)), $urandom % 2 == 1,
                     (($urandom % 50) == 0) || (lp && c >= lim),
                     ($urandom % 5) == 0);
                c++;
            end
            idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0, cyc_now);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
